uart_tx: RTL and testbench

Byte-serial UART transmitter sitting directly downstream of the top-level `txdata`/`txclk`/`txready` port group. It accepts one byte per handshake from the core logic and shifts it onto a single serial line as 8N1, or 8E1 when parity is compiled in. It runs on the 10 MHz `hwclk` and uses an internal bit-period counter, so no external baud clock is needed.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_if.sv | 12 +
 rtl/uart_tx_baud_tick.sv | 28 ++
 rtl/uart_tx.sv | 134 +++++++++++++
 tb/tb_uart_tx.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and system/baud constants.
// Even parity in uart_tx is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  localparam int UART_CLK_HZ    = 10_000_000;
  localparam int UART_BAUD      = 115200;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_if.sv
// Byte handshake between the core logic (master) and the UART transmitter (slave).
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] txdata;
  logic                      txclk;
  logic                      txready;

  modport master (output txdata, output txclk, input  txready);
  modport slave  (input  txdata, input  txclk, output txready);

endinterface : uart_tx_if

// File: rtl/uart_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, pulses tick on the wrap.
module baud_tick #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic hwclk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int              CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering in simulation.
  always_ff @(posedge hwclk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule : baud_tick

// File: rtl/uart_tx.sv
// Byte-serial UART transmitter, 8N1 by default or 8E1 when UART_TX_PARITY_EN is defined.
// All outputs are registered; the bit period comes from the internal baud_tick counter.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = (UART_CLK_HZ + UART_BAUD / 2) / UART_BAUD
) (
  input  logic     hwclk,
  input  logic     reset,
  uart_tx_if.slave txif,
  output logic     tx,
  output logic     busy
);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_t               state, state_next;
  logic [UART_DATA_BITS-1:0] shift, shift_next;
  logic [2:0]                bit_idx, bit_idx_next;
  logic                      tx_next;
  logic                      txready;
  logic                      load;
  logic                      tick;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_next;
`endif

  baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .hwclk  (hwclk),
    .reset  (reset),
    .enable (state != IDLE),
    .clear  (load),
    .tick   (tick)
  );

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    load         = 1'b0;
    tx_next      = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity_q;
`endif

    case (state)
      IDLE: begin
        if (txif.txclk) load = 1'b1;
      end
      START: begin
        if (tick) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shift_next   = shift >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_next = STOP;
      end
`endif
      STOP: begin
        // A strobe held across the end of the stop bit chains straight into the
        // next start bit, so a held txclk streams one byte per frame.
        if (tick) begin
          if (txif.txclk) load = 1'b1;
          else            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      state_next = START;
      shift_next = txif.txdata;
`ifdef UART_TX_PARITY_EN
      parity_next = ^txif.txdata;
`endif
    end

    // Registered line value is derived from where the FSM will be next cycle.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      state    <= IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
      txready  <= 1'b1;
      busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      shift    <= shift_next;
      bit_idx  <= bit_idx_next;
      tx       <= tx_next;
      txready  <= (state_next == IDLE);
      busy     <= (state_next != IDLE);
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_next;
`endif
    end
  end

  assign txif.txready = txready;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames plus hand-written
// back-to-back, mid-frame reset and reset-vs-strobe sequences.
module tb_uart_tx;

  localparam int C = 87;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int F = NBITS * C;

  logic hwclk = 1'b0;
  logic reset = 1'b1;
  logic tx;
  logic busy;

  uart_tx_if u_if ();

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .hwclk (hwclk),
    .reset (reset),
    .txif  (u_if),
    .tx    (tx),
    .busy  (busy)
  );

  always #50 hwclk = ~hwclk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;     // hand-computed even parity of data
    int         inj_at;  // frame cycle at which a 0xFF strobe is injected, -1 for none
    string      nm;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Wait (bounded) for txready, present a byte and return at the negedge after the accept edge.
  task automatic accept(input logic [7:0] d);
    int n = 0;
    while (!u_if.txready && n < 2000) begin
      @(negedge hwclk);
      n++;
    end
    if (!u_if.txready) check("accept_wait_ready", int'(u_if.txready), 1);
    u_if.txdata = d;
    u_if.txclk  = 1'b1;
    @(negedge hwclk);
  endtask

  // Called at the negedge after accept edge k; follows the frame through edge k+F.
  task automatic check_frame(input logic [7:0] data, input logic par, input int inj_at,
                             input logic hold, input logic [7:0] nxt, input string nm);
    logic [10:0] fr;
    int          bad;
    int          b;
    fr = {1'b1, par, data, 1'b0};
`ifndef UART_TX_PARITY_EN
    fr[9] = 1'b1;
`endif
    bad = 0;
    check({nm, "_acc_ready"}, int'(u_if.txready), 0);
    check({nm, "_acc_busy"},  int'(busy), 1);
    check({nm, "_acc_tx"},    int'(tx), 0);
    if (!hold) u_if.txclk = 1'b0;
    for (int cyc = 1; cyc <= F; cyc++) begin
      @(negedge hwclk);
      if (cyc < F) begin
        b = cyc / C;
        if (tx !== fr[b]) bad++;
        if (cyc % C == C / 2) check($sformatf("%s_bit%0d", nm, b), int'(tx), int'(fr[b]));
      end
      if (cyc == inj_at) begin
        u_if.txdata = 8'hFF;
        u_if.txclk  = 1'b1;
      end else if (inj_at >= 0 && cyc == inj_at + 1) begin
        u_if.txclk = 1'b0;
      end
      if (cyc == F - 1) begin
        check({nm, "_ready_last"}, int'(u_if.txready), 0);
        if (hold) u_if.txdata = nxt;
      end
      if (cyc == F) begin
        if (hold) begin
          check({nm, "_chain_tx"},    int'(tx), 0);
          check({nm, "_chain_ready"}, int'(u_if.txready), 0);
          u_if.txclk = 1'b0;
        end else begin
          check({nm, "_end_ready"}, int'(u_if.txready), 1);
          check({nm, "_end_busy"},  int'(busy), 0);
          check({nm, "_end_tx"},    int'(tx), 1);
        end
      end
    end
    check({nm, "_tx_stable"}, bad, 0);
  endtask

  task automatic idle_check(input int n, input string nm);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge hwclk);
      if (tx !== 1'b1 || u_if.txready !== 1'b1 || busy !== 1'b0) bad++;
    end
    check(nm, bad, 0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{data: 8'hA5, par: 1'b0, inj_at: -1,  nm: "a5"};
    vecs[1] = '{data: 8'h01, par: 1'b1, inj_at: -1,  nm: "01"};
    vecs[2] = '{data: 8'h3C, par: 1'b0, inj_at: 300, nm: "3c_inj"};
    vecs[3] = '{data: 8'h00, par: 1'b0, inj_at: -1,  nm: "00"};
    vecs[4] = '{data: 8'hFF, par: 1'b0, inj_at: -1,  nm: "ff"};
    vecs[5] = '{data: 8'h80, par: 1'b1, inj_at: -1,  nm: "80"};

    u_if.txdata = 8'h00;
    u_if.txclk  = 1'b0;
    repeat (3) @(negedge hwclk);
    check("rst_tx",    int'(tx), 1);
    check("rst_ready", int'(u_if.txready), 1);
    check("rst_busy",  int'(busy), 0);
    reset = 1'b0;
    idle_check(200, "idle_200");

    for (int i = 0; i < 6; i++) begin
      accept(vecs[i].data);
      check_frame(vecs[i].data, vecs[i].par, vecs[i].inj_at, 1'b0, 8'h00, vecs[i].nm);
      idle_check(20, {vecs[i].nm, "_gap"});
    end

    // Back-to-back: txclk held high across the first frame chains the second byte.
    accept(8'h55);
    check_frame(8'h55, 1'b0, -1, 1'b1, 8'hAA, "b2b_55");
    check_frame(8'hAA, 1'b0, -1, 1'b0, 8'h00, "b2b_aa");
    idle_check(20, "b2b_gap");

    // Reset at cycle 400 of a frame aborts it.
    accept(8'h3C);
    u_if.txclk = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) @(negedge hwclk);
    reset = 1'b1;
    @(negedge hwclk);
    check("midrst_tx",    int'(tx), 1);
    check("midrst_ready", int'(u_if.txready), 1);
    check("midrst_busy",  int'(busy), 0);
    reset = 1'b0;
    idle_check(50, "midrst_idle");
    accept(8'h0F);
    check_frame(8'h0F, 1'b0, -1, 1'b0, 8'h00, "after_rst_0f");

    // Reset and strobe on the same edge: nothing is accepted.
    u_if.txdata = 8'h77;
    u_if.txclk  = 1'b1;
    reset       = 1'b1;
    @(negedge hwclk);
    reset       = 1'b0;
    u_if.txclk  = 1'b0;
    check("rst_strobe_ready", int'(u_if.txready), 1);
    check("rst_strobe_tx",    int'(tx), 1);
    idle_check(3 * C, "rst_strobe_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_uart_tx
